// File: rtl/stream_frame_capture.sv
// Avalon-ST pixel sink: captures one frame into an inferred block RAM,
// checks SOP/EOP framing against NumPixels and exposes a registered read port.
module stream_frame_capture #(
   parameter int  NumPixels  = 320 * 240,
   parameter int  DATA_WIDTH = 12,
   localparam int ADDR_WIDTH = (NumPixels > 1) ? $clog2(NumPixels) : 1
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [DATA_WIDTH-1:0] data,
   input  logic                  startofpacket,
   input  logic                  endofpacket,
   input  logic                  valid,
   output logic                  ready,
   input  logic                  capture_en,
   input  logic                  clear_err,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data,
   output logic                  frame_done,
   output logic [15:0]           frame_count,
   output logic                  capturing,
   output logic                  err_short,
   output logic                  err_long
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      OVERRUN = 2'd2
   } state_e;

   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(NumPixels - 1);
   localparam logic [ADDR_WIDTH-1:0] AddrOne  = ADDR_WIDTH'(1);

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   wr_addr_q, wr_addr_d;
   logic                    ready_q;
   logic                    frame_done_q, frame_done_d;
   logic [15:0]             frame_count_q, frame_count_d;
   logic                    err_short_q, err_short_d;
   logic                    err_long_q, err_long_d;

   logic                    beat;
   logic                    take;
   logic [ADDR_WIDTH-1:0]   pos;

   logic [DATA_WIDTH-1:0]   mem [NumPixels];
   logic [DATA_WIDTH-1:0]   rd_data_q;

   // An SOP beat always lands at address 0, so a fresh frame and a restart
   // share the same per-beat rules as any other captured beat.
   always_comb begin
      beat          = valid && ready_q;
      take          = beat && ((state_q == CAPTURE) || (startofpacket && capture_en));
      pos           = startofpacket ? '0 : wr_addr_q;
      state_d       = state_q;
      wr_addr_d     = wr_addr_q;
      frame_done_d  = 1'b0;
      frame_count_d = frame_count_q;
      err_short_d   = err_short_q && !clear_err;
      err_long_d    = err_long_q && !clear_err;

      if (take) begin
         if (startofpacket && (state_q == CAPTURE)) begin
            err_short_d = 1'b1;
         end
         if (endofpacket) begin
            state_d   = IDLE;
            wr_addr_d = '0;
            if (pos == LastAddr) begin
               frame_done_d  = 1'b1;
               frame_count_d = frame_count_q + 16'd1;
            end else begin
               err_short_d = 1'b1;
            end
         end else if (pos == LastAddr) begin
            state_d    = OVERRUN;
            wr_addr_d  = '0;
            err_long_d = 1'b1;
         end else begin
            state_d   = CAPTURE;
            wr_addr_d = pos + AddrOne;
         end
      end else if (beat && (state_q == OVERRUN) && (startofpacket || endofpacket)) begin
         // Overrun tail ends on EOP; an SOP refused by capture_en also ends it.
         state_d = IDLE;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q       <= IDLE;
         wr_addr_q     <= '0;
         ready_q       <= 1'b0;
         frame_done_q  <= 1'b0;
         frame_count_q <= '0;
         err_short_q   <= 1'b0;
         err_long_q    <= 1'b0;
      end else begin
         state_q       <= state_d;
         wr_addr_q     <= wr_addr_d;
         ready_q       <= 1'b1;
         frame_done_q  <= frame_done_d;
         frame_count_q <= frame_count_d;
         err_short_q   <= err_short_d;
         err_long_q    <= err_long_d;
      end
   end

   // Frame buffer: no reset, read-before-write so a same-address read sees old data.
   always_ff @(posedge clk) begin
      if (take) begin
         mem[pos] <= data;
      end
      rd_data_q <= mem[rd_addr];
   end

   assign ready       = ready_q;
   assign rd_data     = rd_data_q;
   assign frame_done  = frame_done_q;
   assign frame_count = frame_count_q;
   assign capturing   = (state_q == CAPTURE);
   assign err_short   = err_short_q;
   assign err_long    = err_long_q;

endmodule

// File: tb/tb_stream_frame_capture.sv
// Bench for stream_frame_capture: beat-level frame model plus directed frames
// with literal expectations for counts, flags and buffer readback.
module tb_stream_frame_capture;

   localparam int N  = 16;
   localparam int DW = 12;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic [DW-1:0] data = '0;
   logic          startofpacket = 1'b0;
   logic          endofpacket = 1'b0;
   logic          valid = 1'b0;
   logic          ready;
   logic          capture_en = 1'b1;
   logic          clear_err = 1'b0;
   logic [3:0]    rd_addr = '0;
   logic [DW-1:0] rd_data;
   logic          frame_done;
   logic [15:0]   frame_count;
   logic          capturing;
   logic          err_short;
   logic          err_long;

   stream_frame_capture #(.NumPixels(N), .DATA_WIDTH(DW)) dut (
      .clk           (clk),
      .reset_n       (reset_n),
      .data          (data),
      .startofpacket (startofpacket),
      .endofpacket   (endofpacket),
      .valid         (valid),
      .ready         (ready),
      .capture_en    (capture_en),
      .clear_err     (clear_err),
      .rd_addr       (rd_addr),
      .rd_data       (rd_data),
      .frame_done    (frame_done),
      .frame_count   (frame_count),
      .capturing     (capturing),
      .err_short     (err_short),
      .err_long      (err_long)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;
   int done_seen = 0;

   function automatic void chk(input string nm, input int act, input int exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
      end
   endfunction

   // Model: n counts beats since the frame's SOP (uncapped); only beats with
   // n < N are stored, the beat making n == N decides done / long.
   logic [DW-1:0] m_mem [N];
   bit            m_written [N];
   bit            m_ready = 0;
   bit            in_frame = 0;
   int            n = 0;
   bit            m_short = 0;
   bit            m_long = 0;
   logic [15:0]   m_count = '0;
   bit            m_done = 0;
   logic [DW-1:0] exp_rd = '0;
   bit            exp_rd_known = 0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_ready = 0; in_frame = 0; n = 0; m_short = 0; m_long = 0;
         m_count = '0; m_done = 0; exp_rd_known = 0;
      end else begin
         exp_rd = m_mem[rd_addr];
         exp_rd_known = m_written[rd_addr];
         m_done = 0;
         if (clear_err) begin
            m_short = 0;
            m_long = 0;
         end
         if (valid && m_ready) begin
            if (startofpacket) begin
               if (in_frame && n < N) begin
                  m_short = 1;
                  in_frame = 1;
               end else begin
                  in_frame = capture_en;
               end
               n = 0;
            end
            if (in_frame) begin
               if (n < N) begin
                  m_mem[n] = data;
                  m_written[n] = 1;
               end
               n++;
               if (endofpacket) begin
                  if (n == N) begin
                     m_done = 1;
                     m_count = m_count + 16'd1;
                  end else if (n < N) begin
                     m_short = 1;
                  end
                  in_frame = 0;
               end else if (n == N) begin
                  m_long = 1;
               end
            end
         end
         m_ready = 1;
      end
   end

   always @(negedge clk) begin
      chk("ready", ready, m_ready);
      chk("capturing", capturing, (in_frame && n < N));
      chk("frame_done", frame_done, m_done);
      chk("frame_count", frame_count, m_count);
      chk("err_short", err_short, m_short);
      chk("err_long", err_long, m_long);
      if (exp_rd_known) chk("rd_data", rd_data, exp_rd);
      if (frame_done === 1'b1) done_seen++;
   end

   task automatic send(input int len, input int base, input int sop2,
                       input int eop_at, input bit gaps, input int clr_at);
      for (int i = 0; i < len; i++) begin
         if (gaps) begin
            int g = $urandom_range(0, 2);
            for (int k = 0; k < g; k++) begin
               @(negedge clk);
               valid = 1'b0;
               startofpacket = 1'($urandom_range(0, 1));
               endofpacket = 1'($urandom_range(0, 1));
               data = DW'($urandom);
               clear_err = 1'b0;
            end
         end
         @(negedge clk);
         valid = 1'b1;
         data = DW'(base + i);
         startofpacket = (i == 0) || (i == sop2);
         endofpacket = (i == eop_at);
         clear_err = (i == clr_at);
         rd_addr = 4'(i % N);
      end
      @(negedge clk);
      valid = 1'b0;
      startofpacket = 1'b0;
      endofpacket = 1'b0;
      clear_err = 1'b0;
   endtask

   task automatic idle(input int c);
      repeat (c) @(negedge clk);
   endtask

   task automatic pulse_clear();
      @(negedge clk);
      clear_err = 1'b1;
      @(negedge clk);
      clear_err = 1'b0;
   endtask

   task automatic rd_check(input int a, input int e);
      @(negedge clk);
      rd_addr = 4'(a);
      @(negedge clk);
      chk("readback", rd_data, e);
   endtask

   initial begin
      int d0;
      idle(3);
      chk("rst_ready", ready, 0);
      chk("rst_capturing", capturing, 0);
      chk("rst_count", frame_count, 0);
      chk("rst_short", err_short, 0);
      chk("rst_long", err_long, 0);
      chk("rst_done", frame_done, 0);
      reset_n = 1'b1;
      idle(2);
      chk("ready_after_rst", ready, 1);

      // Clean frame, valid held high.
      send(16, 'h100, -1, 15, 0, -1);
      idle(2);
      chk("t1_done", done_seen, 1);
      chk("t1_count", frame_count, 1);
      chk("t1_short", err_short, 0);
      chk("t1_long", err_long, 0);
      for (int i = 0; i < N; i++) rd_check(i, 'h100 + i);

      // Same shape with random valid gaps and junk on idle cycles.
      send(16, 'h300, -1, 15, 1, -1);
      idle(2);
      chk("t2_done", done_seen, 2);
      chk("t2_count", frame_count, 2);
      for (int i = 0; i < N; i++) rd_check(i, 'h300 + i);

      // Short frame, then clear, then a good frame.
      send(10, 'h400, -1, 9, 0, -1);
      idle(2);
      chk("t3_short", err_short, 1);
      chk("t3_done", done_seen, 2);
      chk("t3_count", frame_count, 2);
      pulse_clear();
      chk("t3_cleared", err_short, 0);
      send(16, 'h500, -1, 15, 0, -1);
      idle(2);
      chk("t3_count2", frame_count, 3);

      // Long frame: first 16 pixels kept, tail discarded.
      send(20, 'h600, -1, 19, 0, -1);
      idle(2);
      chk("t4_long", err_long, 1);
      chk("t4_done", done_seen, 3);
      chk("t4_count", frame_count, 3);
      for (int i = 0; i < N; i++) rd_check(i, 'h600 + i);
      pulse_clear();
      chk("t4_cleared", err_long, 0);
      send(16, 'h700, -1, 15, 0, -1);
      idle(2);
      chk("t4_count2", frame_count, 4);

      // SOP restart at beat 7 with clear_err on the same edge.
      send(23, 'h800, 7, 22, 0, 7);
      idle(2);
      chk("t5_short", err_short, 1);
      chk("t5_count", frame_count, 5);
      chk("t5_done", done_seen, 5);
      for (int i = 0; i < N; i++) rd_check(i, 'h807 + i);
      pulse_clear();

      // capture_en low: frame discarded.
      capture_en = 1'b0;
      send(16, 'h900, -1, 15, 0, -1);
      idle(2);
      capture_en = 1'b1;
      chk("t6_count", frame_count, 5);
      chk("t6_done", done_seen, 5);
      rd_check(0, 'h807);
      rd_check(15, 'h816);

      // Reset dropped just after beat 5.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         valid = 1'b1;
         data = DW'('hA00 + i);
         startofpacket = (i == 0);
         endofpacket = 1'b0;
      end
      @(posedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("t7_ready", ready, 0);
      chk("t7_capturing", capturing, 0);
      chk("t7_count", frame_count, 0);
      valid = 1'b0;
      startofpacket = 1'b0;
      idle(3);
      reset_n = 1'b1;
      d0 = done_seen;
      idle(2);
      chk("t7_nodone", done_seen, d0);
      for (int i = 0; i < 6; i++) rd_check(i, 'hA00 + i);
      rd_check(6, 'h80D);
      send(16, 'hB00, -1, 15, 0, -1);
      idle(2);
      chk("t7_count2", frame_count, 1);
      rd_check(3, 'hB03);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
